// File: rtl/d_cache_responder_pkg.sv
// Shared widths, types and address-field helpers for the data-cache responder.
// Address layout: {tag, index, word offset, byte offset}.
package d_cache_responder_pkg;

   localparam int ADDR_WIDTH         = 16;
   localparam int DATA_WIDTH         = 32;
   localparam int INDEX_WIDTH        = 5;
   localparam int BLOCK_OFFSET_WIDTH = 2;
   localparam int BYTE_OFFSET_WIDTH  = 2;
   localparam int TAG_WIDTH          = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH - BYTE_OFFSET_WIDTH;
   localparam int LINE_WORDS         = 1 << BLOCK_OFFSET_WIDTH;
   localparam int LINES              = 1 << INDEX_WIDTH;

   typedef logic [ADDR_WIDTH-1:0]         addr_t;
   typedef logic [DATA_WIDTH-1:0]         word_t;
   typedef logic [TAG_WIDTH-1:0]          tag_t;
   typedef logic [INDEX_WIDTH-1:0]        index_t;
   typedef logic [BLOCK_OFFSET_WIDTH-1:0] offset_t;
   typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_t;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mem_action_t;

   typedef enum logic [2:0] {
      IDLE,
      REFILL_REQ,
      REFILL_DATA,
      REFILL_DONE,
      WRITE_REQ
   } d_cache_state_t;

   function automatic tag_t addr_tag(input addr_t a);
      return a[ADDR_WIDTH-1 -: TAG_WIDTH];
   endfunction

   function automatic index_t addr_index(input addr_t a);
      return a[BYTE_OFFSET_WIDTH + BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
   endfunction

   function automatic offset_t addr_offset(input addr_t a);
      return a[BYTE_OFFSET_WIDTH +: BLOCK_OFFSET_WIDTH];
   endfunction

   function automatic addr_t line_addr(input tag_t t, input index_t i);
      return {t, i, {(BLOCK_OFFSET_WIDTH + BYTE_OFFSET_WIDTH){1'b0}}};
   endfunction

endpackage

// File: rtl/d_cache_responder_if.sv
// Request/response bus between the pipeline glue, the cache and the memory port.
// master = pipeline + memory side, slave = the cache itself.
interface d_cache_responder_if;
   import d_cache_responder_pkg::*;

   logic        in_valid;
   mem_action_t in_mem_action;
   addr_t       in_addr;
   addr_t       in_addr_next;
   word_t       in_data;

   logic        out_valid;
   word_t       out_data;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_write;
   addr_t       mem_req_addr;
   word_t       mem_req_data;
   logic        mem_resp_valid;
   word_t       mem_resp_data;

   modport master (
      output in_valid, in_mem_action, in_addr, in_addr_next, in_data,
      output mem_req_ready, mem_resp_valid, mem_resp_data,
      input  out_valid, out_data,
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
   );

   modport slave (
      input  in_valid, in_mem_action, in_addr, in_addr_next, in_data,
      input  mem_req_ready, mem_resp_valid, mem_resp_data,
      output out_valid, out_data,
      output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
   );

endinterface

// File: rtl/d_cache_responder_array.sv
// Tag and data storage with registered reads; data is banked per word so a
// single word can be written while the whole line is read out.
module d_cache_responder_array
   import d_cache_responder_pkg::*;
(
   input  logic    clk,
   input  index_t  rd_index,
   output tag_t    rd_tag,
   output line_t   rd_line,
   input  logic    we_tag,
   input  logic    we_data,
   input  index_t  wr_index,
   input  offset_t wr_offset,
   input  tag_t    wr_tag,
   input  word_t   wr_data
);

   tag_t tag_mem [LINES];
   tag_t rd_tag_reg;

   always_ff @(posedge clk) begin
      if (we_tag) begin
         tag_mem[wr_index] <= wr_tag;
      end
      rd_tag_reg <= tag_mem[rd_index];
   end

   assign rd_tag = rd_tag_reg;

   genvar gi;
   generate
      for (gi = 0; gi < LINE_WORDS; gi++) begin : g_bank
         word_t data_mem [LINES];
         word_t rd_word_reg;

         always_ff @(posedge clk) begin
            if (we_data && (wr_offset == offset_t'(gi))) begin
               data_mem[wr_index] <= wr_data;
            end
            rd_word_reg <= data_mem[rd_index];
         end

         assign rd_line[gi] = rd_word_reg;
      end
   endgenerate

endmodule

// File: rtl/d_cache_responder.sv
// Blocking, direct-mapped, write-through, no-write-allocate data cache.
// Read hits answer combinationally; misses refill a full line over a word-burst port.
module d_cache_responder
   import d_cache_responder_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   d_cache_responder_if.slave bus
);

   d_cache_state_t state_reg, state_next;
   offset_t        beat_reg, beat_next;
   logic [LINES-1:0] valid_reg, valid_next;
   tag_t           req_tag_reg, req_tag_next;
   index_t         req_index_reg, req_index_next;
   logic           mem_req_valid_reg, mem_req_valid_next;
   logic           mem_req_write_reg, mem_req_write_next;
   addr_t          mem_req_addr_reg, mem_req_addr_next;
   word_t          mem_req_data_reg, mem_req_data_next;

   tag_t    cur_tag;
   index_t  cur_index;
   offset_t cur_offset;
   tag_t    rd_tag;
   line_t   rd_line;
   logic    hit;
   logic    line_fill;
   logic    line_inval;
   logic    we_tag;
   logic    we_data;
   index_t  wr_index;
   offset_t wr_offset;
   word_t   wr_data;

   assign cur_tag    = addr_tag(bus.in_addr);
   assign cur_index  = addr_index(bus.in_addr);
   assign cur_offset = addr_offset(bus.in_addr);
   // Array output corresponds to in_addr because in_addr_next led it by one cycle.
   assign hit        = valid_reg[cur_index] && (rd_tag == cur_tag);

   d_cache_responder_array u_array (
      .clk       (clk),
      .rd_index  (addr_index(bus.in_addr_next)),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .we_tag    (we_tag),
      .we_data   (we_data),
      .wr_index  (wr_index),
      .wr_offset (wr_offset),
      .wr_tag    (req_tag_reg),
      .wr_data   (wr_data)
   );

   genvar gi;
   generate
      for (gi = 0; gi < LINES; gi++) begin : g_valid
         assign valid_next[gi] = (line_fill && (req_index_reg == index_t'(gi))) ? 1'b1 :
                                 (line_inval && (cur_index == index_t'(gi))) ? 1'b0 :
                                 valid_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         beat_reg          <= '0;
         valid_reg         <= '0;
         req_tag_reg       <= '0;
         req_index_reg     <= '0;
         mem_req_valid_reg <= 1'b0;
         mem_req_write_reg <= 1'b0;
         mem_req_addr_reg  <= '0;
         mem_req_data_reg  <= '0;
      end else begin
         state_reg         <= state_next;
         beat_reg          <= beat_next;
         valid_reg         <= valid_next;
         req_tag_reg       <= req_tag_next;
         req_index_reg     <= req_index_next;
         mem_req_valid_reg <= mem_req_valid_next;
         mem_req_write_reg <= mem_req_write_next;
         mem_req_addr_reg  <= mem_req_addr_next;
         mem_req_data_reg  <= mem_req_data_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      beat_next          = beat_reg;
      req_tag_next       = req_tag_reg;
      req_index_next     = req_index_reg;
      mem_req_valid_next = mem_req_valid_reg;
      mem_req_write_next = mem_req_write_reg;
      mem_req_addr_next  = mem_req_addr_reg;
      mem_req_data_next  = mem_req_data_reg;
      bus.out_valid      = 1'b0;
      bus.out_data       = '0;
      line_fill          = 1'b0;
      line_inval         = 1'b0;
      we_tag             = 1'b0;
      we_data            = 1'b0;
      wr_index           = req_index_reg;
      wr_offset          = beat_reg;
      wr_data            = bus.mem_resp_data;

      unique case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               if (bus.in_mem_action == READ) begin
                  if (hit) begin
                     bus.out_valid = 1'b1;
                     bus.out_data  = rd_line[cur_offset];
                  end else begin
                     // Drop the victim now so a partially refilled line is never seen as valid.
                     line_inval         = 1'b1;
                     req_tag_next       = cur_tag;
                     req_index_next     = cur_index;
                     mem_req_valid_next = 1'b1;
                     mem_req_write_next = 1'b0;
                     mem_req_addr_next  = line_addr(cur_tag, cur_index);
                     state_next         = REFILL_REQ;
                  end
               end else begin
                  if (hit) begin
                     we_data   = 1'b1;
                     wr_index  = cur_index;
                     wr_offset = cur_offset;
                     wr_data   = bus.in_data;
                  end
                  mem_req_valid_next = 1'b1;
                  mem_req_write_next = 1'b1;
                  mem_req_addr_next  = {bus.in_addr[ADDR_WIDTH-1:BYTE_OFFSET_WIDTH],
                                        {BYTE_OFFSET_WIDTH{1'b0}}};
                  mem_req_data_next  = bus.in_data;
                  state_next         = WRITE_REQ;
               end
            end
         end
         REFILL_REQ: begin
            if (bus.mem_req_ready) begin
               mem_req_valid_next = 1'b0;
               state_next         = REFILL_DATA;
            end
         end
         REFILL_DATA: begin
            if (bus.mem_resp_valid) begin
               we_data   = 1'b1;
               beat_next = beat_reg + offset_t'(1);
               if (beat_reg == offset_t'(LINE_WORDS - 1)) begin
                  we_tag     = 1'b1;
                  line_fill  = 1'b1;
                  state_next = REFILL_DONE;
               end
            end
         end
         REFILL_DONE: begin
            state_next = IDLE;
         end
         WRITE_REQ: begin
            if (bus.mem_req_ready) begin
               mem_req_valid_next = 1'b0;
               bus.out_valid      = bus.in_valid;
               state_next         = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.mem_req_valid = mem_req_valid_reg;
   assign bus.mem_req_write = mem_req_write_reg;
   assign bus.mem_req_addr  = mem_req_addr_reg;
   assign bus.mem_req_data  = mem_req_data_reg;

endmodule

// File: tb/tb_d_cache_responder.sv
// Directed bench for d_cache_responder: refill, hits, write-through, no-allocate,
// conflict eviction, reset mid-refill and stray memory responses.
module tb_d_cache_responder;
   import d_cache_responder_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   d_cache_responder_if bus ();

   d_cache_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Address is shown on in_addr_next one cycle before the request goes valid.
   task automatic present(input mem_action_t act, input logic [15:0] a, input logic [31:0] d);
      bus.in_valid     = 1'b0;
      bus.in_addr_next = a;
      @(posedge clk); #1;
      bus.in_valid      = 1'b1;
      bus.in_mem_action = act;
      bus.in_addr       = a;
      bus.in_data       = d;
   endtask

   // Called inside a REFILL_REQ cycle; returns one step into the following IDLE cycle.
   task automatic refill_beats(input logic [31:0] base);
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = base + 32'(i);
         @(posedge clk); #1;
      end
      bus.mem_resp_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      bus.in_valid = 1'b0; bus.in_mem_action = READ; bus.in_addr = '0; bus.in_addr_next = '0;
      bus.in_data = '0; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", bus.mem_req_valid); end
      checks++; if (bus.mem_req_write !== 1'b0) begin errors++; $display("FAIL rst_req_write: got %b want 0", bus.mem_req_write); end
      checks++; if (bus.mem_req_addr !== 16'h0) begin errors++; $display("FAIL rst_req_addr: got %h want 0", bus.mem_req_addr); end
      checks++; if (bus.mem_req_data !== 32'h0) begin errors++; $display("FAIL rst_req_data: got %h want 0", bus.mem_req_data); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL post_rst_req_valid: got %b want 0", bus.mem_req_valid); end
      $display("txn reset released");
   endtask

   task automatic test_cold_read();
      present(READ, 16'h0104, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cold_miss_out_valid: got %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL cold_req_valid: got %b want 1", bus.mem_req_valid); end
      checks++; if (bus.mem_req_write !== 1'b0) begin errors++; $display("FAIL cold_req_write: got %b want 0", bus.mem_req_write); end
      checks++; if (bus.mem_req_addr !== 16'h0100) begin errors++; $display("FAIL cold_req_addr: got %h want 0100", bus.mem_req_addr); end
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = 32'hA0 + 32'(i);
         @(negedge clk);
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cold_beat%0d_out_valid: got %b want 0", i, bus.out_valid); end
         @(posedge clk); #1;
      end
      bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cold_bubble_out_valid: got %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cold_done_out_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_data !== 32'hA1) begin errors++; $display("FAIL cold_done_out_data: got %h want 000000a1", bus.out_data); end
      $display("txn read 0104 refill -> %h", bus.out_data);
      present(READ, 16'h0108, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL reread_out_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_data !== 32'hA2) begin errors++; $display("FAIL reread_out_data: got %h want 000000a2", bus.out_data); end
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reread_req_valid: got %b want 0", bus.mem_req_valid); end
      $display("txn read 0108 hit -> %h", bus.out_data);
   endtask

   task automatic test_write_hit();
      present(WRITE, 16'h0108, 32'hDEADBEEF);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL wr_idle_out_valid: got %b want 0", bus.out_valid); end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         bus.mem_req_ready = 1'b0;
         @(negedge clk);
         checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL wr_wait%0d_req_valid: got %b want 1", k, bus.mem_req_valid); end
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL wr_wait%0d_out_valid: got %b want 0", k, bus.out_valid); end
         if (k == 0) begin
            checks++; if (bus.mem_req_write !== 1'b1) begin errors++; $display("FAIL wr_req_write: got %b want 1", bus.mem_req_write); end
            checks++; if (bus.mem_req_addr !== 16'h0108) begin errors++; $display("FAIL wr_req_addr: got %h want 0108", bus.mem_req_addr); end
            checks++; if (bus.mem_req_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_req_data: got %h want deadbeef", bus.mem_req_data); end
         end
      end
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL wr_ready_out_valid: got %b want 1", bus.out_valid); end
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      bus.in_valid      = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL wr_after_req_valid: got %b want 0", bus.mem_req_valid); end
      $display("txn write 0108 <- deadbeef (hit)");
      present(READ, 16'h0108, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL wr_readback_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_readback_data: got %h want deadbeef", bus.out_data); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL wr_readback_no_req: got %b want 0", bus.mem_req_valid); end
      $display("txn read 0108 hit -> deadbeef");
   endtask

   task automatic test_write_miss();
      present(WRITE, 16'h0400, 32'h12345678);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL wmiss_idle_out_valid: got %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.mem_req_write !== 1'b1) begin errors++; $display("FAIL wmiss_req_write: got %b want 1", bus.mem_req_write); end
      checks++; if (bus.mem_req_addr !== 16'h0400) begin errors++; $display("FAIL wmiss_req_addr: got %h want 0400", bus.mem_req_addr); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL wmiss_out_valid: got %b want 1", bus.out_valid); end
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      bus.in_valid      = 1'b0;
      $display("txn write 0400 <- 12345678 (miss)");
      present(READ, 16'h0400, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL noalloc_out_valid: got %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL noalloc_req_valid: got %b want 1", bus.mem_req_valid); end
      checks++; if (bus.mem_req_addr !== 16'h0400) begin errors++; $display("FAIL noalloc_req_addr: got %h want 0400", bus.mem_req_addr); end
      refill_beats(32'hB0);
      @(negedge clk);
      checks++; if (bus.out_data !== 32'hB0) begin errors++; $display("FAIL noalloc_refill_data: got %h want 000000b0", bus.out_data); end
      bus.in_valid = 1'b0;
      $display("txn read 0400 refill -> %h", bus.out_data);
   endtask

   task automatic test_conflict();
      present(READ, 16'h0100, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_data !== 32'hA0) begin errors++; $display("FAIL conf_first_hit: got %h want 000000a0", bus.out_data); end
      present(READ, 16'h8100, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL conf_miss_out_valid: got %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.mem_req_addr !== 16'h8100) begin errors++; $display("FAIL conf_req_addr: got %h want 8100", bus.mem_req_addr); end
      refill_beats(32'hC0);
      @(negedge clk);
      checks++; if (bus.out_data !== 32'hC0) begin errors++; $display("FAIL conf_refill_data: got %h want 000000c0", bus.out_data); end
      $display("txn read 8100 refill -> %h", bus.out_data);
      present(READ, 16'h0100, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL conf_evicted_out_valid: got %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.mem_req_addr !== 16'h0100) begin errors++; $display("FAIL conf_evicted_req_addr: got %h want 0100", bus.mem_req_addr); end
      refill_beats(32'hA0);
      @(negedge clk);
      checks++; if (bus.out_data !== 32'hA0) begin errors++; $display("FAIL conf_reload_data: got %h want 000000a0", bus.out_data); end
      bus.in_valid = 1'b0;
      $display("txn read 0100 refill after eviction -> %h", bus.out_data);
   endtask

   task automatic test_drop_mid_refill();
      present(READ, 16'h0304, 32'h0);
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = 32'hF0 + 32'(i);
         if (i == 1) bus.in_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drop_bubble_out_valid: got %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drop_idle_out_valid: got %b want 0", bus.out_valid); end
      present(READ, 16'h030C, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL drop_installed_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_data !== 32'hF3) begin errors++; $display("FAIL drop_installed_data: got %h want 000000f3", bus.out_data); end
      bus.in_valid = 1'b0;
      $display("txn read 030c hit after abandoned refill -> %h", bus.out_data);
   endtask

   task automatic test_reset_mid_refill();
      present(READ, 16'h0204, 32'h0);
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = 32'hD0 + 32'(i);
         if (i < 2) begin
            @(posedge clk); #1;
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL mrst_out_data: got %h want 0", bus.out_data); end
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL mrst_req_valid: got %b want 0", bus.mem_req_valid); end
      checks++; if (bus.mem_req_addr !== 16'h0) begin errors++; $display("FAIL mrst_req_addr: got %h want 0", bus.mem_req_addr); end
      checks++; if (bus.mem_req_data !== 32'h0) begin errors++; $display("FAIL mrst_req_data: got %h want 0", bus.mem_req_data); end
      bus.mem_resp_valid = 1'b0;
      bus.in_valid       = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      $display("txn reset during refill beat 2");
      present(READ, 16'h0204, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_again_out_valid: got %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL mrst_again_req_valid: got %b want 1", bus.mem_req_valid); end
      checks++; if (bus.mem_req_addr !== 16'h0200) begin errors++; $display("FAIL mrst_again_req_addr: got %h want 0200", bus.mem_req_addr); end
      refill_beats(32'hE0);
      @(negedge clk);
      checks++; if (bus.out_data !== 32'hE1) begin errors++; $display("FAIL mrst_refill_data: got %h want 000000e1", bus.out_data); end
      $display("txn read 0204 refill after reset -> %h", bus.out_data);
      present(READ, 16'h0108, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_cleared_line: got %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      refill_beats(32'h90);
      @(negedge clk);
      checks++; if (bus.out_data !== 32'h92) begin errors++; $display("FAIL mrst_cleared_refill: got %h want 00000092", bus.out_data); end
      bus.in_valid = 1'b0;
      $display("txn read 0108 refill after reset -> %h", bus.out_data);
   endtask

   task automatic test_stray_resp();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = 32'hFFFFFFFF;
         @(negedge clk);
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stray%0d_out_valid: got %b want 0", i, bus.out_valid); end
         checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL stray%0d_req_valid: got %b want 0", i, bus.mem_req_valid); end
      end
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      present(READ, 16'h0208, 32'h0);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stray_hit_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_data !== 32'hE2) begin errors++; $display("FAIL stray_hit_data: got %h want 000000e2", bus.out_data); end
      bus.in_valid = 1'b0;
      $display("txn read 0208 hit after stray beats -> %h", bus.out_data);
   endtask

   initial begin
      test_reset();
      test_cold_read();
      test_write_hit();
      test_write_miss();
      test_conflict();
      test_drop_mid_refill();
      test_reset_mid_refill();
      test_stray_resp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/d_cache_responder.md
Name: d_cache_responder

Overview:
- Responder end of the data-cache request protocol driven by the EX-stage glue. Consumes valid, mem_action, addr, addr_next and data; returns valid and data to the MEM-stage glue.
- Blocking, direct-mapped, write-through, no-write-allocate cache.
- Misses refill a full line over a simple word-burst memory port. Writes are forwarded word-by-word to memory.

Parameters:
- ADDR_WIDTH, 16, byte-address width; matches `ADDR_WIDTH.
- DATA_WIDTH, 32, word width.
- INDEX_WIDTH, 5, log2 of the line count (32 lines).
- BLOCK_OFFSET_WIDTH, 2, log2 of words per line (4).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_mem_action  in  1  0=READ, 1=WRITE
- in_addr  in  ADDR_WIDTH  byte address of the current request
- in_addr_next  in  ADDR_WIDTH  address presented one cycle early, used for the synchronous array read
- in_data  in  DATA_WIDTH  store data
- out_valid  out  1  request completed this cycle
- out_data  out  DATA_WIDTH  load data; meaningful only when out_valid=1 and the request is a READ
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts the request
- mem_req_write  out  1  0=line read, 1=word write
- mem_req_addr  out  ADDR_WIDTH  line-aligned address for reads, word address for writes
- mem_req_data  out  DATA_WIDTH  write data
- mem_resp_valid  in  1  one refill word per beat, in ascending offset order

Behaviour:
- Address split: [1:0] byte offset (ignored), word offset = BLOCK_OFFSET_WIDTH bits, index = INDEX_WIDTH bits, tag = the remaining upper bits.
- Arrays:
  - tag and data arrays are read synchronously at the index of in_addr_next.
  - valid bits are flops.
  - in IDLE, the hit compare uses in_addr's tag against the read-out tag.
- Reset (async): all line valid bits cleared; state=IDLE; out_valid=0; out_data=0; mem_req_valid=0; mem_req_write=0; mem_req_addr=0; mem_req_data=0; beat counter=0.
- FSM states: IDLE, REFILL_REQ, REFILL_DATA, REFILL_DONE, WRITE_REQ.
- IDLE transitions:
  - in_valid & READ & hit: out_valid=1 and out_data=word, combinationally in the same cycle; stay in IDLE.
  - in_valid & READ & miss: go to REFILL_REQ.
  - in_valid & WRITE: on a hit, update the data word now; go to WRITE_REQ. A miss does not allocate.
- REFILL_REQ:
  - mem_req_valid=1, write=0, addr={tag,index,0s}.
  - Advance to REFILL_DATA on mem_req_ready.
- REFILL_DATA:
  - Each mem_resp_valid writes data[index][beat] and increments beat.
  - On the final beat: set valid[index], write the tag, go to REFILL_DONE.
- REFILL_DONE:
  - One bubble cycle for the array re-read; return to IDLE.
  - The request is still held, so it now hits.
- WRITE_REQ:
  - mem_req_valid=1, write=1, addr=in_addr, data=in_data.
  - On mem_req_ready: out_valid=1 in that cycle, return to IDLE.
- Latencies:
  - read hit: 0 cycles.
  - read miss: 1 + handshake wait + 4 beats + 2 cycles.
  - write: 1 cycle + handshake wait.
- Upstream contract: holds in_* stable until out_valid. out_valid is never asserted without in_valid.
- mem_req_valid stays asserted until ready (no retraction). mem_resp_valid outside REFILL_DATA is ignored.
- in_valid deasserted mid-refill: the refill still completes and installs the line; no out_valid is produced.
- Simultaneous mem_req_ready and the state entry cycle are legal; the transition happens that cycle.
- Beat counter wraps to 0 after the final beat.
- Reset mid-refill: the partial line is not marked valid.

Decomposition:
- mips_core_pkg (or mips_core.svh) holds:
  - mem_action_t {READ, WRITE}
  - d_cache_state_t enum
  - derived widths TAG_WIDTH, LINE_WORDS
- One natural sub-module, d_cache_array: synchronous-read tag+data SRAM with word write enable.
- FSM and valid flops stay in the top module.

Test Plan:
- Cold read 0x0104 → REFILL_REQ with addr 0x0100. After 4 beats 0xA0..0xA3, out_valid with out_data=0xA1 (2 cycles after the last beat). An immediate re-read of 0x0108 hits the same cycle with 0xA2.
- Write 0x0108 data 0xDEADBEEF on a hit → mem_req_write=1, addr 0x0108. mem_req_ready held low 3 cycles, then 1; out_valid only in the ready cycle. A later read of 0x0108 returns 0xDEADBEEF with no memory request.
- Write miss to 0x0400 → memory write issued; subsequent read of 0x0400 misses (no allocate).
- Conflict: read 0x0100, then 0x8100 (same index, different tag) → second read refills and evicts; a read of 0x0100 misses again.
- rst_n low during beat 2 of a refill → all outputs reach reset values asynchronously. A read of the same address after reset issues a new REFILL_REQ.
- Stray mem_resp_valid pulses in IDLE → no array change, no out_valid.
